// File: rtl/system_pio_bidir.sv
// rtl/system_pio_bidir.sv - Avalon-MM bidirectional PIO with per-bit direction,
// atomic set/clear, synchronised edge capture and a maskable level interrupt.
module system_pio_bidir #(
   parameter int               WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter logic [WIDTH-1:0] DIR_RESET   = '0,
   parameter int               EDGE_TYPE   = 0,
   parameter int               SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] out_port,
   output logic [WIDTH-1:0] oe,
   output logic             irq
);

   localparam int CW = $clog2(SYNC_STAGES + 2);
   localparam logic [CW-1:0] WARM_MAX = CW'(SYNC_STAGES + 1);

   localparam logic [2:0] A_DATA     = 3'd0;
   localparam logic [2:0] A_DIR      = 3'd1;
   localparam logic [2:0] A_MASK     = 3'd2;
   localparam logic [2:0] A_EDGE     = 3'd3;
   localparam logic [2:0] A_OUTSET   = 3'd4;
   localparam logic [2:0] A_OUTCLEAR = 3'd5;

   logic [WIDTH-1:0] data_out;
   logic [WIDTH-1:0] dir;
   logic [WIDTH-1:0] irq_mask;
   logic [WIDTH-1:0] edge_capture;
   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] in_sync;
   logic [WIDTH-1:0] in_prev;
   logic [CW-1:0]    warm_cnt;
   logic             warm;

   logic             wr;
   logic [WIDTH-1:0] wd;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] edge_sel;
   logic [WIDTH-1:0] edge_hit;
   logic [WIDTH-1:0] clr_bits;
   logic [WIDTH-1:0] rd;

   assign wr = chipselect & ~write_n;
   assign wd = writedata[WIDTH-1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         in_prev <= '0;
      end else begin
         sync_q[0] <= in_port;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         in_prev <= in_sync;
      end
   end

   assign in_sync = sync_q[SYNC_STAGES-1];

   // Detection stays off until the chain and in_prev hold real pin samples,
   // so pins already high at reset release do not look like a rising edge.
   always_ff @(posedge clk) begin
      if (reset)
         warm_cnt <= '0;
      else if (warm_cnt != WARM_MAX)
         warm_cnt <= warm_cnt + 1'b1;
   end

   assign warm = (warm_cnt == WARM_MAX);

   assign rise = in_sync & ~in_prev;
   assign fall = ~in_sync & in_prev;

   always_comb begin
      edge_sel = rise | fall;
      if (EDGE_TYPE == 0)
         edge_sel = rise;
      else if (EDGE_TYPE == 1)
         edge_sel = fall;
   end

   assign edge_hit = edge_sel & ~dir & {WIDTH{warm}};
   assign clr_bits = (wr && address == A_EDGE) ? wd : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         data_out     <= RESET_VALUE;
         dir          <= DIR_RESET;
         irq_mask     <= '0;
         edge_capture <= '0;
      end else begin
         // A new edge wins over a same-cycle write-1-clear.
         edge_capture <= (edge_capture & ~clr_bits) | edge_hit;
         if (wr) begin
            case (address)
               A_DATA:     data_out <= wd;
               A_DIR:      dir      <= wd;
               A_MASK:     irq_mask <= wd;
               A_OUTSET:   data_out <= data_out | wd;
               A_OUTCLEAR: data_out <= data_out & ~wd;
               default:    ;
            endcase
         end
      end
   end

   always_comb begin
      rd = '0;
      case (address)
         A_DATA:  rd = (dir & data_out) | (~dir & in_sync);
         A_DIR:   rd = dir;
         A_MASK:  rd = irq_mask;
         A_EDGE:  rd = edge_capture;
         default: rd = '0;
      endcase
   end

   assign readdata = 32'(rd);
   assign out_port = data_out;
   assign oe       = dir;
   assign irq      = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_system_pio_bidir.sv
// tb/tb_system_pio_bidir.sv - directed and randomized checks of system_pio_bidir
// against a pin-history reference model.
module tb_system_pio_bidir;

   localparam int         W  = 8;
   localparam logic [7:0] RV = 8'hA5;
   localparam logic [7:0] DR = 8'hFF;
   localparam int         ET = 0;
   localparam int         S  = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [7:0]  in_port;
   logic [7:0]  out_port;
   logic [7:0]  oe;
   logic        irq;

   always #5 clk = ~clk;

   system_pio_bidir #(
      .WIDTH(W), .RESET_VALUE(RV), .DIR_RESET(DR), .EDGE_TYPE(ET), .SYNC_STAGES(S)
   ) dut (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata),
      .in_port(in_port), .out_port(out_port), .oe(oe), .irq(irq)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Model: pin value sampled at each clock edge since reset release.
   logic [7:0] m_out, m_dir, m_mask, m_cap;
   logic [7:0] pin_hist [0:4095];
   int         k;

   function automatic logic [7:0] pin_at(input int j);
      return (j < 1) ? 8'h00 : pin_hist[j];
   endfunction

   function automatic logic [31:0] exp_read(input logic [2:0] a);
      logic [7:0] sync_v;
      sync_v = pin_at(k - S + 1);
      case (a)
         3'd0:    return {24'h0, (m_dir & m_out) | (~m_dir & sync_v)};
         3'd1:    return {24'h0, m_dir};
         3'd2:    return {24'h0, m_mask};
         3'd3:    return {24'h0, m_cap};
         default: return 32'h0;
      endcase
   endfunction

   task automatic step();
      logic       wr;
      logic [7:0] wd, ev, prv, cur, clr;
      wr = chipselect & ~write_n;
      wd = writedata[7:0];
      @(posedge clk);
      if (reset) begin
         m_out = RV; m_dir = DR; m_mask = 8'h00; m_cap = 8'h00; k = 0;
      end else begin
         k++;
         pin_hist[k] = in_port;
         prv = pin_at(k - S - 1);
         cur = pin_at(k - S);
         case (ET)
            0:       ev = cur & ~prv;
            1:       ev = ~cur & prv;
            default: ev = cur ^ prv;
         endcase
         if (k < S + 2) ev = 8'h00;
         ev  = ev & ~m_dir;
         clr = (wr && address == 3'd3) ? wd : 8'h00;
         m_cap = (m_cap & ~clr) | ev;
         if (wr) begin
            case (address)
               3'd0: m_out = wd;
               3'd1: m_dir = wd;
               3'd2: m_mask = wd;
               3'd4: m_out = m_out | wd;
               3'd5: m_out = m_out & ~wd;
               default: ;
            endcase
         end
      end
      #1;
      check_val("out_port", {24'h0, out_port}, {24'h0, m_out});
      check_val("oe", {24'h0, oe}, {24'h0, m_dir});
      check_val("irq", {31'h0, irq}, {31'h0, |(m_cap & m_mask)});
      check_val("readdata", readdata, exp_read(address));
   endtask

   task automatic bus(input logic cs, input logic wn, input logic [2:0] a,
                      input logic [31:0] d, input logic [7:0] p);
      chipselect = cs; write_n = wn; address = a; writedata = d; in_port = p;
      step();
   endtask

   task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
      bus(1'b1, 1'b0, a, d, in_port);
   endtask

   task automatic idle(input logic [2:0] a, input logic [7:0] p, input int n);
      for (int i = 0; i < n; i++) bus(1'b0, 1'b1, a, 32'h0, p);
   endtask

   initial begin
      reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = 3'd0;
      writedata = 32'h0; in_port = 8'h00;
      k = 0; m_out = RV; m_dir = DR; m_mask = 8'h00; m_cap = 8'h00;

      // Reset state
      idle(3'd0, 8'h00, 3);
      check_val("rst_out_port", {24'h0, out_port}, 32'hA5);
      check_val("rst_oe", {24'h0, oe}, 32'hFF);
      check_val("rst_irq", {31'h0, irq}, 32'h0);
      check_val("rst_rd0", readdata, 32'h0000_00A5);
      reset = 1'b0;

      // Atomic set / clear
      wr_reg(3'd0, 32'hA0);
      wr_reg(3'd4, 32'h0F);
      check_val("outset", {24'h0, out_port}, 32'hAF);
      check_val("outset_rd", readdata, 32'h0);
      wr_reg(3'd5, 32'hFFFF_FF81);
      check_val("outclear", {24'h0, out_port}, 32'h2E);
      check_val("outclear_rd", readdata, 32'h0);

      // Mixed direction read-back; output bits never capture
      wr_reg(3'd1, 32'h0F);
      wr_reg(3'd0, 32'h3C);
      idle(3'd0, 8'hA5, 3);
      check_val("mixed_rd0", readdata, 32'h0000_00AC);
      for (int i = 0; i < 4; i++) idle(3'd3, (i % 2) ? 8'hA5 : 8'hAA, 3);
      check_val("out_bits_nocap", readdata & 32'h0F, 32'h0);

      // Single rising edge: exact latency, irq, write-1-clear
      idle(3'd3, 8'h00, 5);
      wr_reg(3'd3, 32'hFF);
      wr_reg(3'd1, 32'h00);
      wr_reg(3'd2, 32'h01);
      idle(3'd3, 8'h00, 4);
      idle(3'd3, 8'h01, 1);
      check_val("lat_e1", readdata, 32'h0);
      idle(3'd3, 8'h01, 1);
      check_val("lat_e2", readdata, 32'h0);
      idle(3'd3, 8'h01, 1);
      check_val("lat_e3", readdata, 32'h1);
      check_val("lat_irq", {31'h0, irq}, 32'h1);
      wr_reg(3'd3, 32'h01);
      check_val("w1c_cap", readdata, 32'h0);
      check_val("w1c_irq", {31'h0, irq}, 32'h0);

      // Clear and new edge in the same cycle: set wins
      wr_reg(3'd2, 32'h04);
      idle(3'd3, 8'h04, 3);
      check_val("b2_set", readdata & 32'h4, 32'h4);
      idle(3'd3, 8'h00, 3);
      idle(3'd3, 8'h04, 2);
      wr_reg(3'd3, 32'h04);
      check_val("set_wins", readdata & 32'h4, 32'h4);
      check_val("set_wins_irq", {31'h0, irq}, 32'h1);

      // Inputs high through reset release: no spurious capture
      in_port = 8'hFF;
      reset = 1'b1;
      idle(3'd3, 8'hFF, 2);
      reset = 1'b0;
      wr_reg(3'd1, 32'h00);
      for (int i = 0; i < 20; i++) begin
         idle(3'd3, 8'hFF, 1);
         check_val("warm_nocap", readdata, 32'h0);
      end
      idle(3'd3, 8'hF7, 3);
      idle(3'd3, 8'hFF, 3);
      check_val("rise_only", readdata, 32'h08);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic [7:0] p;
         p = in_port;
         if ($urandom_range(0, 3) == 0) p = 8'($urandom);
         reset = ($urandom_range(0, 99) == 0);
         bus(1'($urandom), 1'($urandom), 3'($urandom), $urandom, p);
      end
      reset = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
